// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: chunk sizing,
// operation encoding and the signed-overflow rule used by the final stage.
package adder_pkg;

  // Operation select carried on the 'sub' input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Width of one ripple chunk; the top rejects configurations that do not divide evenly.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Two's-complement overflow: both addends share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple-carry adder; one instance per pipeline stage.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  // Ripple the carry bit by bit from the LSB to the MSB of the chunk.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = c_in;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement add/subtract unit.
// The WIDTH-bit operation is split into STAGES equal ripple chunks, one chunk
// per clock, with the carry registered between stages. The operands that are
// still to be added and the sum chunks already produced travel with the op.
// A single global advance enable gives full backpressure without bubble
// collapsing, so ordering is always preserved.
// Optional build macro ADD_SATURATE_EN: on signed overflow the final stage
// clamps the sum to the signed max/min instead of wrapping.
module pipelined_adder_sub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int C = chunk_w(WIDTH, STAGES);

`ifdef ADD_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Per-stage record: operands (b already inverted for subtract), the sum
  // chunks produced so far, the carry into the next chunk and, in the last
  // stage, the overflow flag.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES");
  end

  logic en_s;
  op_e  op_s;

  // The whole pipeline advances when the output slot is empty or being drained.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;
  assign op_s     = op_e'(sub);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         src_s;
    stage_t         nxt_s;
    stage_t         stg_r;
    logic [C-1:0]   chunk_sum_s;
    logic           chunk_cout_s;

    if (k == 0) begin : g_src_in
      // First stage takes the operands straight from the ports; subtract is
      // a + ~b + ~c_in so that c_in acts as a borrow.
      always_comb begin
        src_s       = '0;
        src_s.valid = in_valid;
        src_s.a     = a;
        if (op_s == OP_SUB) begin
          src_s.b     = ~b;
          src_s.carry = ~c_in;
        end else begin
          src_s.b     = b;
          src_s.carry = c_in;
        end
      end
    end else begin : g_src_prev
      // Later stages consume the record registered by the previous stage.
      always_comb begin
        src_s = g_stage[k-1].stg_r;
      end
    end

    chunk_adder #(
      .W(C)
    ) u_chunk (
      .a     (src_s.a[k*C +: C]),
      .b     (src_s.b[k*C +: C]),
      .c_in  (src_s.carry),
      .sum   (chunk_sum_s),
      .c_out (chunk_cout_s)
    );

    // Merge this stage's chunk into the record; the last stage also forms
    // the overflow flag and, when enabled, the saturated result.
    always_comb begin
      nxt_s                = src_s;
      nxt_s.sum[k*C +: C]  = chunk_sum_s;
      nxt_s.carry          = chunk_cout_s;
      if (k == (STAGES - 1)) begin
        nxt_s.ovf = signed_ovf(src_s.a[WIDTH-1], src_s.b[WIDTH-1], chunk_sum_s[C-1]);
`ifdef ADD_SATURATE_EN
        if (nxt_s.ovf) begin
          nxt_s.sum = src_s.a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
          nxt_s.sum = nxt_s.sum;
        end
`endif
      end else begin
        nxt_s.ovf = src_s.ovf;
      end
    end

    // Stage register: cleared by reset, loaded on advance, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_r <= '0;
      end else if (en_s) begin
        stg_r <= nxt_s;
      end else begin
        stg_r <= stg_r;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].stg_r.valid;
  assign sum       = g_stage[STAGES-1].stg_r.sum;
  assign c_out     = g_stage[STAGES-1].stg_r.carry;
  assign ovf       = g_stage[STAGES-1].stg_r.ovf;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Self-checking bench for pipelined_adder_sub (WIDTH=32, STAGES=4).
// A queue-based reference model computes every result with plain integer
// arithmetic; a negedge compare process checks each delivered result.
module tb_pipelined_adder_sub;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          c_in = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          ovf;

  int            total = 0;
  int            bad = 0;
  int            delivered = 0;
  logic [33:0]   exp_q[$];
  logic [33:0]   exp_e;

  pipelined_adder_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, c_out, sum} from integer arithmetic on the operands.
  function automatic logic [33:0] model(input logic [31:0] ai, input logic [31:0] bi,
                                        input logic ci, input logic si);
    longint      sa, sb, sr;
    logic [32:0] ur;
    logic [31:0] s;
    logic        cy, o;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (!si) begin
      ur = {1'b0, ai} + {1'b0, bi} + {32'd0, ci};
      s  = ur[31:0];
      cy = ur[32];
      sr = sa + sb + longint'(ci);
    end else begin
      s  = ai - bi - {31'd0, ci};
      cy = ({1'b0, ai} >= ({1'b0, bi} + {32'd0, ci}));
      sr = sa - sb - longint'(ci);
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADD_SATURATE_EN
    if (o) s = ai[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {o, cy, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: handshake bookkeeping and result checking each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", {30'd0, ovf, c_out, sum}, {30'd0, exp_e});
          delivered++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  // Single op into an idle pipe: pin the model to a literal and check latency.
  task automatic directed(input string name, input logic [31:0] ai, input logic [31:0] bi,
                          input logic ci, input logic si, input logic [33:0] lit);
    check({name, "_model"}, {30'd0, model(ai, bi, ci, si)}, {30'd0, lit});
    @(posedge clk); #1;
    a = ai; b = bi; c_in = ci; sub = si; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (S - 2) @(posedge clk);
    #1 check({name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_lit"}, {30'd0, ovf, c_out, sum}, {30'd0, lit});
  endtask

  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic new_op();
    int pick;
    pick = $urandom_range(0, 4);
    case (pick)
      0: a = 32'h0000_0000;
      1: a = 32'hFFFF_FFFF;
      2: a = 32'h8000_0000;
      3: a = 32'h7FFF_FFFF;
      default: a = $urandom;
    endcase
    b    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    c_in = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  localparam logic [33:0] L_OVF_ADD =
`ifdef ADD_SATURATE_EN
    {1'b1, 1'b1, 32'h8000_0000};
`else
    {1'b1, 1'b1, 32'h0000_0000};
`endif
  localparam logic [33:0] L_OVF_SUB =
`ifdef ADD_SATURATE_EN
    {1'b1, 1'b0, 32'h7FFF_FFFF};
`else
    {1'b1, 1'b0, 32'h8000_0000};
`endif

  initial begin
    int acc, d0, vcount;
    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout_ovf", {62'd0, c_out, ovf}, 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Directed vectors
    directed("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {1'b0, 1'b1, 32'hFFFF_FFFF});
    directed("min_plus_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, L_OVF_ADD);
    directed("ripple_all", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    directed("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    directed("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, L_OVF_SUB);
    directed("sub_borrow", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0006});
    drain("directed");

    // Eight back-to-back ops with the consumer stalled in cycles 3..5
    d0 = delivered;
    acc = 0;
    @(posedge clk); #1;
    new_op();
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (acc < 8);
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (cyc == 4 || cyc == 5) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (cyc == 3) check("prefill_in_ready", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (in_valid && acc < 8) new_op();
    end
    drain("stall");
    check("stall_count", 64'(delivered - d0), 64'd8);

    // Randomized traffic with random backpressure
    new_op();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = (in_valid && in_ready) ? 1 : 0;
      @(posedge clk); #1;
      if (acc == 1) new_op();
    end
    drain("random");

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      a = 32'h1234_0000 + 32'(i); b = 32'h0000_1111; c_in = 1'b0; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_sum", 64'(sum), 64'd0);
    check("rst_flush_flags", {62'd0, c_out, ovf}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("no_stale_after_rst", 64'(vcount), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
